// File: rtl/imm_issue_ctrl_pkg.sv
// Shared definitions for the ID-stage immediate sequencer: EXTOp codes, opcodes,
// skid-buffer state codes and the opcode decode helper.
package imm_issue_ctrl_pkg;

    localparam logic [1:0] EXTOP_ZERO = 2'b00;
    localparam logic [1:0] EXTOP_SIGN = 2'b01;
    localparam logic [1:0] EXTOP_HIGH = 2'b10;

    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic       uses_imm;
        logic [1:0] extop;
    } dec_t;

    function automatic dec_t decode_op(input logic [5:0] op);
        dec_t d;
        d.uses_imm = 1'b1;
        d.extop    = EXTOP_ZERO;
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_BEQ, OP_BNE, OP_LW, OP_SW:  d.extop = EXTOP_SIGN;
            OP_ANDI, OP_ORI, OP_XORI:      d.extop = EXTOP_ZERO;
            OP_LUI:                        d.extop = EXTOP_HIGH;
            default:                       d.uses_imm = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_issue_ctrl_ext.sv
// Immediate extender: widens a 16-bit immediate to 32 bits according to EXTOp.
module imm_issue_ctrl_ext
    import imm_issue_ctrl_pkg::*;
(
    input  logic [1:0]  extop,
    input  logic [15:0] imm16,
    output logic [31:0] imm32
);

    always_comb begin
        imm32 = {16'h0000, imm16};
        case (extop)
            EXTOP_SIGN: imm32 = {{16{imm16[15]}}, imm16};
            EXTOP_HIGH: imm32 = {imm16, 16'h0000};
            default:    imm32 = {16'h0000, imm16};
        endcase
    end

endmodule

// File: rtl/imm_issue_ctrl.sv
// ID-stage immediate sequencer: decode, extend, and a 2-entry skid buffer toward ID/EX.
// Optional performance counters are built when IMM_CTRL_PERF_EN is defined.
module imm_issue_ctrl
    import imm_issue_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_imm32,
    output logic [1:0]  out_extop,
    output logic        out_uses_imm,
`ifdef IMM_CTRL_PERF_EN
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall,
`endif
    output buf_state_t  dbg_state
);

    // Handshake: a transfer happens on an edge where valid and ready are both high.
    // in_ready is registered (state != FULL) and never looks at out_ready.
    buf_state_t  state;
    dec_t        dec;
    logic [31:0] new_imm32;
    logic [31:0] tail_imm32;
    logic [1:0]  tail_extop;
    logic        tail_uses_imm;
    logic        accept;
    logic        consume;
    logic        unused_instr_bits;

    assign dec               = decode_op(in_instr[31:26]);
    assign accept            = in_valid & in_ready;
    assign consume           = out_valid & out_ready;
    assign dbg_state         = state;
    assign unused_instr_bits = ^in_instr[25:16];

    imm_issue_ctrl_ext u_ext (
        .extop (dec.extop),
        .imm16 (in_instr[15:0]),
        .imm32 (new_imm32)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_EMPTY;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_imm32     <= 32'h0;
            out_extop     <= EXTOP_ZERO;
            out_uses_imm  <= 1'b0;
            tail_imm32    <= 32'h0;
            tail_extop    <= EXTOP_ZERO;
            tail_uses_imm <= 1'b0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_imm32    <= new_imm32;
                        out_extop    <= dec.extop;
                        out_uses_imm <= dec.uses_imm;
                        out_valid    <= 1'b1;
                        state        <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        out_imm32    <= new_imm32;
                        out_extop    <= dec.extop;
                        out_uses_imm <= dec.uses_imm;
                    end else if (accept) begin
                        tail_imm32    <= new_imm32;
                        tail_extop    <= dec.extop;
                        tail_uses_imm <= dec.uses_imm;
                        in_ready      <= 1'b0;
                        state         <= ST_FULL;
                    end else if (consume) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // Tail slides into the head on the same edge the head leaves.
                    if (consume) begin
                        out_imm32    <= tail_imm32;
                        out_extop    <= tail_extop;
                        out_uses_imm <= tail_uses_imm;
                        in_ready     <= 1'b1;
                        state        <= ST_ONE;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMM_CTRL_PERF_EN
    // Counters survive flush; a consume that coincides with flush is discarded, so not issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issued <= 32'h0;
            perf_stall  <= 32'h0;
        end else begin
            if (consume && !flush)
                perf_issued <= perf_issued + 32'h1;
            if (out_valid && !out_ready)
                perf_stall <= perf_stall + 32'h1;
        end
    end
`endif

endmodule
